// File: rtl/dcache_pkg.sv
// dcache_pkg: shared FSM type, line geometry and address-field helpers for the L1 data cache.
package dcache_pkg;
    localparam int LINE_W = 256;
    localparam int OFFSET_W = 5;
    localparam int WORD_SEL_W = 3;
    typedef enum logic [1:0] {IDLE, WB_WAIT, RD_WAIT, REFILL} state_t;
    function automatic int index_w(input int sets);
        return $clog2(sets);
    endfunction
    function automatic int tag_w(input int sets);
        return 32 - OFFSET_W - $clog2(sets);
    endfunction
    function automatic logic [31:0] addr_index(input logic [31:0] a, input int iw);
        return (a >> OFFSET_W) & ((32'd1 << iw) - 32'd1);
    endfunction
    function automatic logic [31:0] addr_tag(input logic [31:0] a, input int iw);
        return a >> (OFFSET_W + iw);
    endfunction
    function automatic logic [WORD_SEL_W-1:0] addr_word(input logic [31:0] a);
        return a[OFFSET_W-1:2];
    endfunction
endpackage

// File: rtl/dcache_sram.sv
// dcache_sram: two-way tag/data store with valid, dirty and per-set LRU state.
// One write per cycle: either a whole-line refill into fill_way or a store word into the hit way.
module dcache_sram
    import dcache_pkg::*;
#(
    parameter int NUM_SETS = 16
) (
    input  logic                      clk_i,
    input  logic                      start_i,
    input  logic [index_w(NUM_SETS)-1:0] idx,
    input  logic [tag_w(NUM_SETS)-1:0]   tag,
    input  logic [WORD_SEL_W-1:0]     word,
    input  logic                      acc_en,
    input  logic                      st_en,
    input  logic [31:0]               st_data,
    input  logic                      fill_en,
    input  logic                      fill_way,
    input  logic [LINE_W-1:0]         fill_line,
    output logic                      hit,
    output logic                      hit_way,
    output logic [31:0]               rd_word,
    output logic                      victim_way,
    output logic                      victim_dirty,
    output logic [tag_w(NUM_SETS)-1:0]   victim_tag,
    output logic [LINE_W-1:0]         victim_line
);
    localparam int TW = tag_w(NUM_SETS);
    logic [TW-1:0] tag_q [2][NUM_SETS];
    logic [LINE_W-1:0] data_q [2][NUM_SETS];
    logic [NUM_SETS-1:0] valid_q [2];
    logic [NUM_SETS-1:0] dirty_q [2];
    logic [NUM_SETS-1:0] lru_q;
    logic [1:0] match;

    always_comb begin
        match[0] = valid_q[0][idx] && tag_q[0][idx] == tag;
        match[1] = valid_q[1][idx] && tag_q[1][idx] == tag;
        hit = |match;
        hit_way = match[1];
        rd_word = data_q[hit_way][idx][{word, 5'b0} +: 32];
        victim_way = !valid_q[0][idx] ? 1'b0 : !valid_q[1][idx] ? 1'b1 : lru_q[idx];
        victim_dirty = dirty_q[victim_way][idx];
        victim_tag = tag_q[victim_way][idx];
        victim_line = data_q[victim_way][idx];
    end

    // LRU bit names the way to evict next, so an access points it at the other way
    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            valid_q <= '{default: '0};
            dirty_q <= '{default: '0};
            lru_q <= '0;
        end else if (fill_en) begin
            valid_q[fill_way][idx] <= 1'b1;
            dirty_q[fill_way][idx] <= 1'b0;
        end else if (acc_en) begin
            lru_q[idx] <= ~hit_way;
            if (st_en)
                dirty_q[hit_way][idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (fill_en) begin
            tag_q[fill_way][idx] <= tag;
            data_q[fill_way][idx] <= fill_line;
        end else if (acc_en && st_en) begin
            data_q[hit_way][idx][{word, 5'b0} +: 32] <= st_data;
        end
    end
endmodule

// File: rtl/dcache_controller.sv
// dcache_controller: two-way write-back/write-allocate L1 D-cache with a single-outstanding
// line-wide memory port; a miss stalls the pipeline until the line is refilled and the access hits.
module dcache_controller
    import dcache_pkg::*;
#(
    parameter int NUM_SETS = 16,
    parameter int LINE_BYTES = 32
) (
    input  logic                    clk_i,
    input  logic                    start_i,
    input  logic                    cpu_req_i,
    input  logic                    cpu_we_i,
    input  logic [31:0]             cpu_addr_i,
    input  logic [31:0]             cpu_data_i,
    output logic [31:0]             cpu_data_o,
    output logic                    cpu_stall_o,
    output logic                    mem_enable_o,
    output logic                    mem_write_o,
    output logic [31:0]             mem_addr_o,
    output logic [LINE_BYTES*8-1:0] mem_data_o,
    input  logic [LINE_BYTES*8-1:0] mem_data_i,
    input  logic                    mem_ack_i
);
    localparam int IW = index_w(NUM_SETS);
    localparam int TW = tag_w(NUM_SETS);
    state_t state;
    logic [IW-1:0] idx, miss_idx;
    logic [TW-1:0] tag, miss_tag, victim_tag;
    logic miss_way, hit, hit_way, victim_way, victim_dirty, acc, miss, fill_en;
    logic [31:0] rd_word;
    logic [LINE_W-1:0] victim_line;

    // Outside IDLE the arrays are addressed by the latched miss, not the live CPU inputs
    always_comb begin
        idx = state == IDLE ? IW'(addr_index(cpu_addr_i, IW)) : miss_idx;
        tag = state == IDLE ? TW'(addr_tag(cpu_addr_i, IW)) : miss_tag;
        acc = state == IDLE && cpu_req_i && hit;
        miss = state == IDLE && cpu_req_i && !hit;
        fill_en = state == RD_WAIT && mem_ack_i;
        cpu_stall_o = miss || state != IDLE;
        cpu_data_o = acc && !cpu_we_i ? rd_word : '0;
    end

    dcache_sram #(.NUM_SETS(NUM_SETS)) u_sram (
        .clk_i        (clk_i),
        .start_i      (start_i),
        .idx          (idx),
        .tag          (tag),
        .word         (addr_word(cpu_addr_i)),
        .acc_en       (acc),
        .st_en        (cpu_we_i),
        .st_data      (cpu_data_i),
        .fill_en      (fill_en),
        .fill_way     (miss_way),
        .fill_line    (mem_data_i),
        .hit          (hit),
        .hit_way      (hit_way),
        .rd_word      (rd_word),
        .victim_way   (victim_way),
        .victim_dirty (victim_dirty),
        .victim_tag   (victim_tag),
        .victim_line  (victim_line)
    );

    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            state <= IDLE;
            miss_idx <= '0;
            miss_tag <= '0;
            miss_way <= 1'b0;
            mem_enable_o <= 1'b0;
            mem_write_o <= 1'b0;
            mem_addr_o <= '0;
            mem_data_o <= '0;
        end else begin
            mem_enable_o <= 1'b0;
            case (state)
                IDLE: if (miss) begin
                    miss_idx <= idx;
                    miss_tag <= tag;
                    miss_way <= victim_way;
                    mem_enable_o <= 1'b1;
                    mem_write_o <= victim_dirty;
                    mem_addr_o <= {victim_dirty ? victim_tag : tag, idx, {OFFSET_W{1'b0}}};
                    if (victim_dirty)
                        mem_data_o <= victim_line;
                    state <= victim_dirty ? WB_WAIT : RD_WAIT;
                end
                WB_WAIT: if (mem_ack_i) begin
                    mem_enable_o <= 1'b1;
                    mem_write_o <= 1'b0;
                    mem_addr_o <= {miss_tag, miss_idx, {OFFSET_W{1'b0}}};
                    state <= RD_WAIT;
                end
                RD_WAIT: if (mem_ack_i)
                    state <= REFILL;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dcache_controller.sv
// tb_dcache_controller: randomized scoreboard bench; reference is a golden word memory plus
// per-set recency lists, with a latency-programmable line memory responder.
module tb_dcache_controller;
    logic clk_i = 0, start_i = 1, cpu_req_i = 0, cpu_we_i = 0, mem_ack_i = 0;
    logic [31:0] cpu_addr_i = 0, cpu_data_i = 0, cpu_data_o, mem_addr_o;
    logic cpu_stall_o, mem_enable_o, mem_write_o;
    logic [255:0] mem_data_o, mem_data_i = 0;

    typedef struct {bit w; logic [31:0] a; logic [255:0] d;} mem_t;
    typedef struct {int stall; logic [31:0] d;} cmp_t;
    mem_t mem_q[$];
    cmp_t cmp_q[$];
    logic [31:0] gold[int unsigned];
    logic [31:0] bmem[int unsigned];
    int unsigned lines[16][$];
    bit dirty[int unsigned];
    int lat = 10, rst_gen = 0, spur_req = 0, n_vec = 0, n_err = 0;
    bit done = 0;

    always #5 clk_i = ~clk_i;

    dcache_controller dut (
        .clk_i(clk_i), .start_i(start_i), .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i),
        .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o),
        .cpu_stall_o(cpu_stall_o), .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_data_i(mem_data_i),
        .mem_ack_i(mem_ack_i)
    );

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return a == 32'h408 ? 32'hDEAD_BEEF : a * 32'h9E37_79B1 ^ 32'h5A5A_1234;
    endfunction
    function automatic logic [31:0] rd(input logic [31:0] a, input bit g);
        if (g)
            return gold.exists(a) ? gold[a] : dflt(a);
        return bmem.exists(a) ? bmem[a] : dflt(a);
    endfunction
    function automatic logic [255:0] line_of(input logic [31:0] base, input bit g);
        logic [255:0] l;
        for (int i = 0; i < 8; i++)
            l[i*32 +: 32] = rd(base + 32'(i * 4), g);
        return l;
    endfunction

    task automatic chk(input bit ok, input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: a miss costs 3+L, plus L+1 when the least-recent line of a full set is dirty
    task automatic model(input bit we, input logic [31:0] a, input logic [31:0] d);
        int set;
        int pos;
        int stall;
        logic [31:0] base;
        logic [31:0] v;
        set = int'(a[8:5]);
        base = a & ~32'd31;
        pos = -1;
        stall = 0;
        for (int i = 0; i < lines[set].size(); i++)
            if (lines[set][i] == base) pos = i;
        if (pos >= 0) begin
            lines[set].delete(pos);
        end else begin
            stall = 3 + lat;
            if (lines[set].size() == 2) begin
                v = lines[set].pop_back();
                if (dirty.exists(v)) begin
                    mem_q.push_back('{1'b1, v, line_of(v, 1)});
                    dirty.delete(v);
                    stall = 4 + 2 * lat;
                end
            end
            mem_q.push_back('{1'b0, base, '0});
        end
        lines[set].push_front(base);
        if (we) begin
            gold[a & ~32'd3] = d;
            dirty[base] = 1;
        end
        cmp_q.push_back('{stall, we ? 32'd0 : rd(a & ~32'd3, 1)});
    endtask

    task automatic model_reset();
        for (int s = 0; s < 16; s++)
            lines[s].delete();
        dirty.delete();
        mem_q.delete();
        cmp_q.delete();
        gold = bmem;
        rst_gen++;
    endtask

    task automatic access(input bit we, input logic [31:0] a, input logic [31:0] d);
        model(we, a, d);
        cpu_req_i = 1;
        cpu_we_i = we;
        cpu_addr_i = a;
        cpu_data_i = d;
        for (int i = 0; ; i++) begin
            @(negedge clk_i);
            if (!cpu_stall_o) break;
            if (i > 300) begin
                $display("FAIL access_timeout: addr %0h still stalled", a);
                $fatal(1);
            end
        end
        @(posedge clk_i);
        #1;
        cpu_req_i = 0;
    endtask

    task automatic idle(input int n);
        cpu_req_i = 0;
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    // Memory responder: ack exactly lat cycles after the enable cycle; reset abandons the request
    initial begin
        int cnt = 0, gen = 0, spur_done = 0;
        bit pend = 0;
        logic [31:0] pa = 0;
        forever begin
            @(posedge clk_i);
            #1;
            mem_ack_i = 0;
            if (pend && gen != rst_gen) pend = 0;
            if (pend) cnt--;
            if (pend && cnt == 0) begin
                mem_ack_i = 1;
                mem_data_i = line_of(pa, 0);
                pend = 0;
            end else if (spur_done != spur_req) begin
                spur_done = spur_req;
                mem_ack_i = 1;
                mem_data_i = {8{$urandom}};
            end
            if (mem_enable_o && start_i) begin
                pend = 1;
                cnt = lat;
                gen = rst_gen;
                pa = mem_addr_o;
                if (mem_write_o)
                    for (int i = 0; i < 8; i++)
                        bmem[mem_addr_o + 32'(i * 4)] = mem_data_o[i*32 +: 32];
            end
        end
    end

    // Monitor: pops expectations whenever the DUT issues a request or completes an access
    initial begin
        int scnt = 0;
        mem_t e;
        cmp_t c;
        forever begin
            @(negedge clk_i);
            if (!start_i) begin
                scnt = 0;
                chk({cpu_stall_o, mem_enable_o, mem_write_o, mem_addr_o, cpu_data_o} == 67'd0,
                    "reset_outputs", 256'({cpu_stall_o, mem_enable_o, mem_write_o, mem_addr_o, cpu_data_o}), 256'd0);
                chk(mem_data_o == 256'd0, "reset_mem_data", mem_data_o, 256'd0);
            end else begin
                if (mem_enable_o) begin
                    chk(mem_q.size() != 0, "mem_unexpected", 256'(mem_addr_o), 256'd0);
                    if (mem_q.size() != 0) begin
                        e = mem_q.pop_front();
                        chk(mem_write_o == e.w, "mem_write", 256'(mem_write_o), 256'(e.w));
                        chk(mem_addr_o == e.a, "mem_addr", 256'(mem_addr_o), 256'(e.a));
                        if (e.w)
                            chk(mem_data_o == e.d, "wb_data", mem_data_o, e.d);
                    end
                end
                if (!cpu_req_i) begin
                    chk(!cpu_stall_o, "idle_stall", 256'(cpu_stall_o), 256'd0);
                end else if (cpu_stall_o) begin
                    scnt++;
                end else begin
                    chk(cmp_q.size() != 0, "cpu_unexpected", 256'(cpu_addr_i), 256'd0);
                    if (cmp_q.size() != 0) begin
                        c = cmp_q.pop_front();
                        chk(scnt == c.stall, "stall_cycles", 256'(scnt), 256'(c.stall));
                        chk(cpu_data_o == c.d, "cpu_data", 256'(cpu_data_o), 256'(c.d));
                    end
                    scnt = 0;
                end
            end
            if (done) break;
        end
        chk(mem_q.size() == 0, "mem_missing", 256'(mem_q.size()), 256'd0);
        chk(cmp_q.size() == 0, "cpu_missing", 256'(cmp_q.size()), 256'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        logic [31:0] a;
        #2 start_i = 0;
        model_reset();
        repeat (2) @(posedge clk_i);
        #1 start_i = 1;
        lat = 10;
        access(0, 32'h408, 0);
        access(1, 32'h404, 32'h1234_5678);
        access(0, 32'h404, 0);
        access(0, 32'hC00, 0);
        access(0, 32'h400, 0);
        access(0, 32'h1400, 0);
        access(0, 32'h400, 0);
        access(1, 32'h400, 32'hA5A5_0001);
        access(0, 32'hC00, 0);
        access(0, 32'hC00, 0);
        access(0, 32'h1400, 0);
        idle(2);
        spur_req++;
        idle(3);
        access(0, 32'hC00, 0);
        access(0, 32'h1404, 0);
        // Reset while the refill read is outstanding
        model(0, 32'h2000, 0);
        cpu_req_i = 1;
        cpu_we_i = 0;
        cpu_addr_i = 32'h2000;
        for (int i = 0; ; i++) begin
            @(negedge clk_i);
            if (mem_enable_o && !mem_write_o) break;
            if (i > 100) begin
                $display("FAIL read_issue_timeout: no read request seen");
                $fatal(1);
            end
        end
        repeat (3) @(posedge clk_i);
        #1;
        start_i = 0;
        cpu_req_i = 0;
        model_reset();
        repeat (2) @(posedge clk_i);
        #1 start_i = 1;
        idle(2);
        access(0, 32'hC00, 0);
        for (int n = 0; n < 250; n++) begin
            lat = $urandom_range(1, 6);
            a = (32'($urandom_range(0, 5)) << 9) | (32'($urandom_range(0, 1)) << 5) | (32'($urandom_range(0, 7)) << 2);
            if ($urandom_range(0, 1) == 1) a = a | 32'h8000_0000;
            access(1'($urandom_range(0, 1)), a, $urandom);
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        idle(20);
        done = 1;
    end
endmodule

// File: doc/dcache_controller.md
# dcache_controller

Two-way set-associative, write-back, write-allocate L1 data cache for the pipelined CPU's MEM stage. Sits directly upstream of the MEM/WB pipeline register: it supplies the load data that register captures and drives the global stall that freezes every pipeline register during a miss. Misses are serviced by a single-outstanding-request, line-wide handshake to off-chip data memory.

## Interface
- `NUM_SETS`, 16, number of sets (power of two); index width = log2(NUM_SETS)
- `LINE_BYTES`, 32, line size; 8 words of 32 bits; offset width 5
- `clk_i`  in  1  clock
- `start_i`  in  1  asynchronous, active-low reset (one clock; reset is asynchronous and active-low)
- `cpu_req_i`  in  1  MEM-stage access valid (MemRead or MemWrite)
- `cpu_we_i`  in  1  1 = store, 0 = load
- `cpu_addr_i`  in  32  byte address; bits [1:0] ignored
- `cpu_data_i`  in  32  store data
- `cpu_data_o`  out  32  load data to MEM/WB
- `cpu_stall_o`  out  1  pipeline stall
- `mem_enable_o`  out  1  one-cycle memory request pulse
- `mem_write_o`  out  1  request is a write-back
- `mem_addr_o`  out  32  line-aligned address (bits [4:0] = 0)
- `mem_data_o`  out  256  write-back line
- `mem_data_i`  in  256  refill line, valid with ack
- `mem_ack_i`  in  1  one-cycle completion pulse

## Operation
- Address split: tag = [31:5+IDX], index = [4+IDX:5], word = [4:2].
- Lookup is combinational in IDLE: hit = valid & tag match in either way.
- Load hit: `cpu_data_o` = selected word same cycle; LRU bit of set points at the other way at the clock edge.
- Store hit: at the edge, word replaced, dirty set, LRU updated. `cpu_data_o` = 0 when no load hit.
- `cpu_stall_o` = (IDLE & cpu_req_i & ~hit) | (state != IDLE).
- Victim: first invalid way (way 0 before way 1), else way indicated by LRU.
- FSM states: IDLE, WB_WAIT, RD_WAIT, REFILL.
  - IDLE, miss, victim dirty -> WB_WAIT; issue write: addr = {victim tag, index, 5'b0}, data = victim line.
  - IDLE, miss, victim clean/invalid -> RD_WAIT; issue read: addr = {tag, index, 5'b0}.
  - WB_WAIT, ack -> RD_WAIT; issue read of missing line.
  - RD_WAIT, ack -> REFILL; victim way written with `mem_data_i`, tag, valid = 1, dirty = 0.
  - REFILL -> IDLE unconditionally; the access then hits and completes as a normal hit (store merges then).
- Miss address, way and index latched on leaving IDLE; CPU inputs need not be re-sampled until IDLE.
- `mem_ack_i` outside WB_WAIT/RD_WAIT ignored. At most one outstanding request.
- Reset (any time, including mid-miss): state IDLE; all valid, dirty, LRU bits 0; `mem_enable_o`, `mem_write_o` 0, `mem_addr_o` 0, `mem_data_o` 0; in-flight memory transaction abandoned. Data/tag arrays need not be cleared.

## Timing
- Memory request outputs registered: `mem_enable_o` high exactly one cycle after each issuing edge; addr/data/write held until next issue.
- Memory latency L = cycles from enable-high cycle to ack-high cycle.
- Hit: zero stall cycles.
- Clean miss: miss detected cycle 0; enable cycle 1; ack cycle 1+L; REFILL cycle 2+L; hit cycle 3+L. Stall high cycles 0..2+L (3+L cycles).
- Dirty miss: write enable cycle 1, ack 1+L, read enable 2+L, ack 2+2L, REFILL 3+2L; stall high 4+2L cycles.
- Back-to-back hits sustain one access per cycle; stall-free cycle after a miss can itself miss.

## Structure
- Package `dcache_pkg`: state enum, LINE_W = 256, OFFSET_W = 5, WORD_SEL_W = 3, derived INDEX_W/TAG_W, address-field functions.
- Sub-module `dcache_sram`: two-way tag/data arrays plus valid, dirty, per-set LRU bit; provides hit, hit way, read line/word, victim selection; single write port per way (line or word write).
- Top holds the FSM, miss latches and memory-interface registers.

## Test plan
- Reset, load 0x0000_0400 (L=10, mem returns line word2 = 0xDEAD_BEEF at word offset for addr 0x408 test) -> stall 13 cycles, one read at 0x400, then `cpu_data_o` correct, no write issued.
- Store 0x1234_5678 to 0x404 after fill, then load 0x404 -> both hit, 0 stall, load returns 0x1234_5678.
- Fill 0x400, 0xC00 (same set 0), touch 0x400, miss on 0x1400 -> victim is 0xC00's way; dirty 0x400 untouched.
- Dirty victim: store to 0x400, fill 0xC00, touch 0xC00, load 0x1400 -> write at 0x400 with modified line, then read 0x1400; stall 24 cycles.
- Spurious `mem_ack_i` in IDLE -> no state or array change.
- Assert `start_i` low during RD_WAIT -> outputs zeroed, stall low after release, previously filled line now misses.
